pdm_mic_buffer: RTL and testbench

//  Upstream stage of the PDM audio path. Captures the 1-bit PDM stream from the

---
 rtl/pdm_mic_buffer.sv | 145 ++++++++++++++
 tb/tb_pdm_mic_buffer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pdm_mic_buffer.sv
// PDM microphone capture buffer: synchronizes the 1-bit mic stream, waits out the
// mic start-up settle window, then stores samples in a bit-wide circular FIFO.
//
// state   | meaning
// IDLE    | capture stopped; FIFO may still be drained
// SETTLE  | mic warming up; samples discarded until the settle counter reaches 0
// CAPTURE | writing one sample every SAMPLE_DIV mclk cycles
module pdm_mic_buffer #(
    parameter int DEPTH      = 64,
    parameter int AW         = 6,
    parameter int SETTLE_CYC = 1024,
    parameter int SAMPLE_DIV = 1
) (
    input  logic          mclk,
    input  logic          reset,
    input  logic          enable,
    input  logic          micData,
    input  logic          rd_toggle,
    output logic          dout,
    output logic          empty,
    output logic          full,
    output logic          overflow,
    output logic [AW:0]   count,
    output logic          capturing
);

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t          state;
    logic [SW-1:0]   settle_cnt;
    logic [DW-1:0]   divider;
    logic            mic_meta;
    logic            mic_s;
    logic            rd_q;
    logic [DEPTH-1:0] mem;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            wr_stb;
    logic            pop;
    logic            pop_ok;
    logic            wr_ok;
    logic [AW:0]     count_next;

    always_ff @(posedge mclk) begin
        if (reset) begin
            state      <= IDLE;
            settle_cnt <= '0;
            divider    <= '0;
            capturing  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state      <= SETTLE;
                        settle_cnt <= SW'(SETTLE_CYC - 1);
                    end
                end
                SETTLE: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (settle_cnt == '0) begin
                        state     <= CAPTURE;
                        divider   <= '0;
                        capturing <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                CAPTURE: begin
                    if (!enable) begin
                        state     <= IDLE;
                        capturing <= 1'b0;
                    end else if (divider == DW'(SAMPLE_DIV - 1)) begin
                        divider <= '0;
                    end else begin
                        divider <= divider + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    capturing <= 1'b0;
                end
            endcase
        end
    end

    // Dropping enable suppresses the write in the same cycle the FSM leaves CAPTURE.
    assign wr_stb = (state == CAPTURE) && enable && (divider == DW'(SAMPLE_DIV - 1));
    assign pop    = rd_toggle ^ rd_q;
    assign pop_ok = pop & ~empty;
    // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
    assign wr_ok  = wr_stb & (~full | pop_ok);

    always_comb begin
        count_next = count;
        if (wr_ok && !pop_ok) begin
            count_next = count + 1'b1;
        end else if (pop_ok && !wr_ok) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge mclk) begin
        if (reset) begin
            mic_meta <= 1'b0;
            mic_s    <= 1'b0;
            rd_q     <= 1'b0;
            mem      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            mic_meta <= micData;
            mic_s    <= mic_meta;
            rd_q     <= rd_toggle;
            if (wr_ok) begin
                mem[wr_ptr] <= mic_s;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (wr_stb && !wr_ok) begin
                overflow <= 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == (AW + 1)'(DEPTH));
        end
    end

    // Fall-through head; stale bits are visible while empty and are don't-care.
    assign dout = mem[rd_ptr];

endmodule

// File: tb/tb_pdm_mic_buffer.sv
// Directed bench for pdm_mic_buffer: a cycle table for settle/order/full/drain,
// plus sequences for reset mid-capture and a divided sample rate.
module tb_pdm_mic_buffer;

    logic       mclk;
    logic       reset;
    logic       enable;
    logic       enable_b;
    logic       micData;
    logic       rd_toggle;

    logic       dout_a, empty_a, full_a, overflow_a, capturing_a;
    logic [2:0] count_a;
    logic       dout_b, empty_b, full_b, overflow_b, capturing_b;
    logic [3:0] count_b;

    int tests = 0;
    int fails = 0;

    pdm_mic_buffer #(.DEPTH(4), .AW(2), .SETTLE_CYC(8), .SAMPLE_DIV(1)) dut_a (
        .mclk(mclk), .reset(reset), .enable(enable), .micData(micData),
        .rd_toggle(rd_toggle), .dout(dout_a), .empty(empty_a), .full(full_a),
        .overflow(overflow_a), .count(count_a), .capturing(capturing_a)
    );

    pdm_mic_buffer #(.DEPTH(8), .AW(3), .SETTLE_CYC(4), .SAMPLE_DIV(3)) dut_b (
        .mclk(mclk), .reset(reset), .enable(enable_b), .micData(micData),
        .rd_toggle(rd_toggle), .dout(dout_b), .empty(empty_b), .full(full_b),
        .overflow(overflow_b), .count(count_b), .capturing(capturing_b)
    );

    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    typedef struct {
        logic rst;
        logic en;
        logic mic;
        logic rd;
        int   cnt;
        logic emp;
        logic ful;
        logic ovf;
        logic cap;
        int   dout;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic r, logic e, logic m, logic rd, int c,
                                logic em, logic fu, logic ov, logic ca, int d);
        vec_t v;
        v.rst = r; v.en = e; v.mic = m; v.rd = rd; v.cnt = c;
        v.emp = em; v.ful = fu; v.ovf = ov; v.cap = ca; v.dout = d;
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    initial begin
        int exp_b[11];
        reset = 1'b1; enable = 1'b0; enable_b = 1'b0; micData = 1'b0; rd_toggle = 1'b0;

        // dout of -1 means head is don't-care (FIFO empty after wrap)
        for (int i = 0; i < 3; i++) add(1, 1, (i == 1) ? 1'b0 : 1'b1, 0, 0, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 4; i < 10; i++) add(0, 1, logic'(i % 2), 0, 0, 1, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 1, 0, 0, 1, 0);
        add(0, 1, 1, 0, 1, 0, 0, 0, 1, 1);
        add(0, 1, 1, 0, 2, 0, 0, 0, 1, 1);
        add(0, 1, 0, 0, 3, 0, 0, 0, 1, 1);
        add(0, 1, 1, 0, 4, 0, 1, 0, 1, 1);
        add(0, 1, 1, 1, 4, 0, 1, 0, 1, 0);
        add(0, 1, 0, 0, 4, 0, 1, 0, 1, 1);
        add(0, 1, 0, 0, 4, 0, 1, 1, 1, 1);
        add(0, 0, 0, 0, 4, 0, 1, 1, 0, 1);
        add(0, 0, 0, 1, 3, 0, 0, 1, 0, 1);
        add(0, 0, 0, 0, 2, 0, 0, 1, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0, 1, 0, 1);
        add(0, 0, 0, 0, 0, 1, 0, 1, 0, -1);
        add(0, 0, 0, 1, 0, 1, 0, 1, 0, -1);
        add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 27; i < 33; i++) add(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 1, 0, 0, 1, 0);
        add(0, 1, 1, 1, 1, 0, 0, 0, 1, 1);
        add(0, 1, 0, 0, 1, 0, 0, 0, 1, 0);
        add(0, 1, 0, 1, 1, 0, 0, 0, 1, 1);
        add(0, 0, 0, 1, 1, 0, 0, 0, 0, 1);

        foreach (vecs[i]) begin
            reset     = vecs[i].rst;
            enable    = vecs[i].en;
            micData   = vecs[i].mic;
            rd_toggle = vecs[i].rd;
            tick();
            chk($sformatf("v%0d_count", i), int'(count_a), vecs[i].cnt);
            chk($sformatf("v%0d_empty", i), int'(empty_a), int'(vecs[i].emp));
            chk($sformatf("v%0d_full", i), int'(full_a), int'(vecs[i].ful));
            chk($sformatf("v%0d_overflow", i), int'(overflow_a), int'(vecs[i].ovf));
            chk($sformatf("v%0d_capturing", i), int'(capturing_a), int'(vecs[i].cap));
            if (vecs[i].dout >= 0)
                chk($sformatf("v%0d_dout", i), int'(dout_a), vecs[i].dout);
        end

        // reset during CAPTURE with three bits stored, then a full settle again
        reset = 1'b1; enable = 1'b0; rd_toggle = 1'b0; micData = 1'b0;
        tick();
        reset = 1'b0; enable = 1'b1;
        tick();
        repeat (8) tick();
        chk("mid_cap_before", int'(capturing_a), 1);
        micData = 1'b1;
        repeat (3) tick();
        chk("mid_count3", int'(count_a), 3);
        reset = 1'b1;
        tick();
        chk("mid_rst_count", int'(count_a), 0);
        chk("mid_rst_cap", int'(capturing_a), 0);
        chk("mid_rst_empty", int'(empty_a), 1);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("mid_settle_e%0d_count", k), int'(count_a), (k == 9) ? 1 : 0);
            if (k == 8) chk("mid_settle_cap", int'(capturing_a), 1);
        end

        // divided sample rate on the second instance
        exp_b = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 2};
        reset = 1'b1; enable = 1'b0; enable_b = 1'b0;
        tick();
        reset = 1'b0; enable_b = 1'b1;
        for (int k = 0; k < 11; k++) begin
            tick();
            chk($sformatf("div_e%0d_count", k), int'(count_b), exp_b[k]);
            if (k == 3) chk("div_cap_pre", int'(capturing_b), 0);
            if (k == 4) chk("div_cap", int'(capturing_b), 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
